// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared fetch definitions: FSM state encodings, NOP constant and widths,
// reused by fetch, decode and hazard logic.
package pc_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_KILL  = 2'd3
    } fetch_state_e;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] NOP_INSTR_C = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP     = 32'd4;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
        return a & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry pc/instruction holding buffer used when decode stalls
// on the same cycle a fetch response returns.
module fetch_skid_buf
    import pc_fetch_ctrl_pkg::*;
#(
    parameter logic [ILEN-1:0] NOP_INSTR = NOP_INSTR_C
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            i_load,
    input  logic            i_drain,
    input  logic            i_clear,
    input  logic [XLEN-1:0] i_pc,
    input  logic [ILEN-1:0] i_instr,
    output logic            o_full,
    output logic [XLEN-1:0] o_pc,
    output logic [ILEN-1:0] o_instr
);

    logic            r_full;
    logic [XLEN-1:0] r_pc;
    logic [ILEN-1:0] r_instr;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_full  <= 1'b0;
            r_pc    <= '0;
            r_instr <= NOP_INSTR;
        end else if (i_clear) begin
            r_full  <= 1'b0;
        end else if (i_load) begin
            r_full  <= 1'b1;
            r_pc    <= i_pc;
            r_instr <= i_instr;
        end else if (i_drain) begin
            r_full  <= 1'b0;
        end
    end

    assign o_full  = r_full;
    assign o_pc    = r_pc;
    assign o_instr = r_instr;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// RV32 instruction-fetch sequencer: PC, I-cache handshake, IF/ID register.
// Define PC_FETCH_PERF_EN to add the fetch/kill performance counters.
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [ILEN-1:0] NOP_INSTR = NOP_INSTR_C
`ifdef PC_FETCH_PERF_EN
    ,
    parameter int PERF_W = 32
`endif
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            mem_read_o,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic            mem_stall_i,
    input  logic [ILEN-1:0] mem_rdata_i,
    output logic            if_valid_o,
    output logic [XLEN-1:0] if_pc_o,
    output logic [ILEN-1:0] if_instr_o
`ifdef PC_FETCH_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_fetch_o,
    output logic [PERF_W-1:0] perf_kill_o
`endif
);

    fetch_state_e    r_state;
    fetch_state_e    w_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pend;
    logic            r_if_valid;
    logic [XLEN-1:0] r_if_pc;
    logic [ILEN-1:0] r_if_instr;

    logic [XLEN-1:0] w_target;
    logic            w_read;
    logic            w_ifid_mem;
    logic            w_ifid_skid;
    logic            w_ifid_bubble;
    logic            w_skid_load;
    logic            w_skid_drain;
    logic            w_pc_inc;
    logic            w_pc_redir;
    logic            w_pc_pend;
    logic            w_pend_load;
    logic            w_kill;

    logic            w_skid_full;
    logic [XLEN-1:0] w_skid_pc;
    logic [ILEN-1:0] w_skid_instr;

    assign w_target = align_pc(redirect_pc_i);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  w_next = ST_FETCH;
            ST_FETCH: begin
                if (redirect_i)
                    w_next = mem_stall_i ? ST_KILL : ST_FETCH;
                else if (!mem_stall_i && stall_i)
                    w_next = ST_HOLD;
            end
            ST_HOLD:  if (redirect_i || !stall_i) w_next = ST_FETCH;
            ST_KILL:  if (!mem_stall_i) w_next = ST_FETCH;
        endcase
    end

    always_comb begin
        w_read        = 1'b0;
        w_ifid_mem    = 1'b0;
        w_ifid_skid   = 1'b0;
        w_ifid_bubble = 1'b0;
        w_skid_load   = 1'b0;
        w_skid_drain  = 1'b0;
        w_pc_inc      = 1'b0;
        w_pc_redir    = 1'b0;
        w_pc_pend     = 1'b0;
        w_pend_load   = 1'b0;
        w_kill        = 1'b0;
        unique case (r_state)
            ST_IDLE: w_pc_redir = redirect_i;
            ST_FETCH: begin
                w_read = 1'b1;
                if (redirect_i) begin
                    w_ifid_bubble = 1'b1;
                    w_pend_load   = mem_stall_i;
                    w_pc_redir    = !mem_stall_i;
                    w_kill        = !mem_stall_i;
                end else if (!mem_stall_i) begin
                    w_pc_inc    = 1'b1;
                    w_skid_load = stall_i;
                    w_ifid_mem  = !stall_i;
                end else begin
                    w_ifid_bubble = !stall_i;
                end
            end
            ST_HOLD: begin
                if (redirect_i) begin
                    w_ifid_bubble = 1'b1;
                    w_pc_redir    = 1'b1;
                end else if (!stall_i && w_skid_full) begin
                    w_ifid_skid  = 1'b1;
                    w_skid_drain = 1'b1;
                end
            end
            ST_KILL: begin
                w_read        = 1'b1;
                w_ifid_bubble = redirect_i || !stall_i;
                w_pend_load   = redirect_i && mem_stall_i;
                w_pc_redir    = redirect_i && !mem_stall_i;
                w_pc_pend     = !redirect_i && !mem_stall_i;
                w_kill        = !mem_stall_i;
            end
        endcase
    end

    // The address only moves on an accepted response or a redirect,
    // so it stays stable across cache stalls and the KILL drain.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_pc   <= RESET_PC;
            r_pend <= RESET_PC;
        end else begin
            if (w_pc_redir)     r_pc <= w_target;
            else if (w_pc_pend) r_pc <= r_pend;
            else if (w_pc_inc)  r_pc <= r_pc + PC_STEP;
            if (w_pend_load)    r_pend <= w_target;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_if_valid <= 1'b0;
            r_if_pc    <= '0;
            r_if_instr <= NOP_INSTR;
        end else if (w_ifid_mem) begin
            r_if_valid <= 1'b1;
            r_if_pc    <= r_pc;
            r_if_instr <= mem_rdata_i;
        end else if (w_ifid_skid) begin
            r_if_valid <= 1'b1;
            r_if_pc    <= w_skid_pc;
            r_if_instr <= w_skid_instr;
        end else if (w_ifid_bubble) begin
            r_if_valid <= 1'b0;
            r_if_pc    <= '0;
            r_if_instr <= NOP_INSTR;
        end
    end

    fetch_skid_buf #(
        .NOP_INSTR (NOP_INSTR)
    ) u_skid (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .i_load  (w_skid_load),
        .i_drain (w_skid_drain),
        .i_clear (redirect_i),
        .i_pc    (r_pc),
        .i_instr (mem_rdata_i),
        .o_full  (w_skid_full),
        .o_pc    (w_skid_pc),
        .o_instr (w_skid_instr)
    );

`ifdef PC_FETCH_PERF_EN
    logic [PERF_W-1:0] r_perf_fetch;
    logic [PERF_W-1:0] r_perf_kill;
    localparam logic [PERF_W-1:0] ONE = {{(PERF_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_perf_fetch <= '0;
            r_perf_kill  <= '0;
        end else begin
            if (w_ifid_mem || w_ifid_skid) r_perf_fetch <= r_perf_fetch + ONE;
            if (w_kill)                    r_perf_kill  <= r_perf_kill + ONE;
        end
    end

    assign perf_fetch_o = r_perf_fetch;
    assign perf_kill_o  = r_perf_kill;
`endif

    assign mem_read_o = w_read;
    assign mem_addr_o = r_pc;
    assign if_valid_o = r_if_valid;
    assign if_pc_o    = r_if_pc;
    assign if_instr_o = r_if_instr;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Randomized scoreboard bench for pc_fetch_ctrl against a stream-level
// model of the fetch pipeline (pc, pending kill, skid slot, IF/ID slot).
module tb_pc_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redir = 1'b0;
    logic [31:0] redir_pc = '0;
    logic        mem_read;
    logic [31:0] mem_addr;
    logic        mem_stall = 1'b0;
    logic [31:0] mem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5C3_0001;
    endfunction

    assign mem_rdata = mem_word(mem_addr);

    pc_fetch_ctrl dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .stall_i       (stall),
        .redirect_i    (redir),
        .redirect_pc_i (redir_pc),
        .mem_read_o    (mem_read),
        .mem_addr_o    (mem_addr),
        .mem_stall_i   (mem_stall),
        .mem_rdata_i   (mem_rdata),
        .if_valid_o    (if_valid),
        .if_pc_o       (if_pc),
        .if_instr_o    (if_instr)
    );

    typedef struct {
        logic        rd;
        logic        chk_addr;
        logic [31:0] addr;
        logic        v;
        logic        chk_pc;
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    logic        m_started, m_kill, m_skid_v, m_v;
    logic [31:0] m_pc, m_pend, m_skid_pc, m_skid_ins, m_ipc, m_ins;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("mem_read", {31'b0, mem_read}, {31'b0, e.rd});
                if (e.chk_addr) chk("mem_addr", mem_addr, e.addr);
                chk("if_valid", {31'b0, if_valid}, {31'b0, e.v});
                if (e.chk_pc) chk("if_pc", if_pc, e.pc);
                chk("if_instr", if_instr, e.v ? e.ins : NOP);
            end
        end
    end

    task automatic model_reset();
        m_started = 0; m_kill = 0; m_skid_v = 0; m_v = 0;
        m_pc = 32'h0; m_pend = 32'h0; m_skid_pc = 0; m_skid_ins = NOP;
        m_ipc = 32'h0; m_ins = NOP;
    endtask

    function automatic exp_t reset_rec();
        exp_t e;
        e.rd = 0; e.chk_addr = 1; e.addr = 32'h0;
        e.v = 0; e.chk_pc = 1; e.pc = 32'h0; e.ins = NOP;
        return e;
    endfunction

    // Entered #1 after a rising edge; returns #1 after a rising edge
    task automatic do_reset();
        #1;
        rst_n = 0; stall = 0; redir = 0; mem_stall = 0; redir_pc = 0;
        q.push_back(reset_rec());
        @(posedge clk); #1;
        q.push_back(reset_rec());
        @(posedge clk); #1;
        model_reset();
        rst_n = 1;
    endtask

    task automatic model_step(input logic rd, input logic [31:0] rpc,
                              input logic st, input logic ms);
        logic        reading;
        logic [31:0] tgt;
        reading = m_started && !m_skid_v;
        tgt = {rpc[31:2], 2'b00};
        if (!m_started) begin
            m_started = 1;
            if (rd) m_pc = tgt;
        end else if (rd) begin
            m_v = 0;
            m_skid_v = 0;
            if (reading && ms) begin
                m_kill = 1;
                m_pend = tgt;
            end else begin
                m_kill = 0;
                m_pc = tgt;
            end
        end else if (reading && !ms && m_kill) begin
            m_kill = 0;
            m_pc = m_pend;
            if (!st) m_v = 0;
        end else if (reading && !ms) begin
            if (st) begin
                m_skid_v = 1; m_skid_pc = m_pc; m_skid_ins = mem_word(m_pc);
            end else begin
                m_v = 1; m_ipc = m_pc; m_ins = mem_word(m_pc);
            end
            m_pc = m_pc + 32'd4;
        end else if (m_skid_v && !st) begin
            m_v = 1; m_ipc = m_skid_pc; m_ins = m_skid_ins;
            m_skid_v = 0;
        end else if (!st) begin
            m_v = 0;
        end
    endtask

    initial begin
        exp_t        e;
        logic        rd, st, ms;
        logic [31:0] rpc;
        bit          want_rst;
        int          wait_n;
        want_rst = 0;
        wait_n = 0;
        model_reset();
        @(posedge clk); #1;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 1000 || cyc == 2000) begin
                want_rst = 1;
                wait_n = 0;
            end
            if (want_rst && (m_kill || wait_n > 300)) begin
                want_rst = 0;
                do_reset();
            end
            if (want_rst) wait_n++;
            e.rd = m_started && !m_skid_v;
            e.chk_addr = e.rd;
            e.addr = m_pc;
            e.v = m_v;
            e.chk_pc = m_v;
            e.pc = m_ipc;
            e.ins = m_ins;
            q.push_back(e);
            if (cyc < 20) begin
                st = 0; ms = 0; rd = 0; rpc = 0;
            end else begin
                st = ($urandom_range(99) < 25);
                ms = ($urandom_range(99) < 30);
                rd = m_started && ($urandom_range(99) < 7);
                case ($urandom_range(3))
                    0: rpc = 32'h0000_0100;
                    1: rpc = 32'hFFFF_FFF8;
                    2: rpc = 32'hFFFF_FFFC;
                    default: rpc = $urandom;
                endcase
                rpc = rpc | 32'($urandom_range(3));
            end
            stall = st; mem_stall = ms; redir = rd; redir_pc = rpc;
            model_step(rd, rpc, st, ms);
            @(posedge clk); #1;
        end
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
